klingon_decoder: RTL and testbench

KLINGON_DECODER -- requirements
Module: klingon_decoder

---
 rtl/klingon_decoder.sv | 145 ++++++++++++++
 tb/tb_klingon_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/klingon_decoder.sv
// klingon_decoder: accepts Klingon seven-segment digits over a valid/ready
// stream, accumulates up to MAX_DIGITS decimal digits and presents the
// binary result (or an error flag) over a second valid/ready stream.
// Optional feature macro: KLINGON_BLANK_EN makes the blank pattern 0000000
// a legal "no digit" symbol that may still carry LAST.
module klingon_decoder #(
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] SEG_IN,
  input  logic       SEG_VALID,
  input  logic       LAST,
  output logic       SEG_READY,
  output logic [9:0] NUM_OUT,
  output logic       NUM_VALID,
  input  logic       NUM_READY,
  output logic       ERR
);

  localparam logic [1:0] LP_MAX = 2'(MAX_DIGITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_OUT,
    ST_ERROR
  } state_t;

  state_t     r_state;
  logic [9:0] r_acc;
  logic [1:0] r_cnt;
  logic [9:0] r_num_out;
  logic       r_num_valid;
  logic       r_err;
  logic       r_seg_ready;

  logic [3:0] w_digit;
  logic       w_legal;
  logic       w_blank;
  logic [9:0] w_acc_next;
  logic [1:0] w_cnt_next;
  logic       w_term;

  // Segment pattern to decimal digit lookup
  always_comb begin
    w_digit = '0;
    w_legal = 1'b1;
    w_blank = 1'b0;
    case (SEG_IN)
      7'b1111110: w_digit = 4'd0;
      7'b1000000: w_digit = 4'd1;
      7'b1000001: w_digit = 4'd2;
      7'b1001001: w_digit = 4'd3;
      7'b0100011: w_digit = 4'd4;
      7'b0011101: w_digit = 4'd5;
      7'b0100101: w_digit = 4'd6;
      7'b0010011: w_digit = 4'd7;
      7'b0110110: w_digit = 4'd8;
      7'b0110111: w_digit = 4'd9;
`ifdef KLINGON_BLANK_EN
      7'b0000000: w_blank = 1'b1;
`endif
      default:    w_legal = 1'b0;
    endcase
  end

  // Next accumulator / count and termination decision for a real digit
  always_comb begin
    w_acc_next = 10'(r_acc * 10'd10 + {6'b0, w_digit});
    w_cnt_next = r_cnt + 2'd1;
    w_term     = LAST || (w_cnt_next == LP_MAX);
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_num_out   <= '0;
      r_num_valid <= 1'b0;
      r_err       <= 1'b0;
      r_seg_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (SEG_VALID) begin
            if (!w_legal) begin
              r_state     <= ST_ERROR;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_num_out   <= '0;
              r_num_valid <= 1'b1;
              r_err       <= 1'b1;
              r_seg_ready <= 1'b0;
            end else if (w_blank) begin
              // Blank keeps ACC/count; it only matters when it ends the number
              if (LAST) begin
                r_state     <= ST_OUT;
                r_num_out   <= r_acc;
                r_num_valid <= 1'b1;
                r_err       <= 1'b0;
                r_seg_ready <= 1'b0;
              end
            end else begin
              r_acc <= w_acc_next;
              r_cnt <= w_cnt_next;
              if (w_term) begin
                r_state     <= ST_OUT;
                r_num_out   <= w_acc_next;
                r_num_valid <= 1'b1;
                r_err       <= 1'b0;
                r_seg_ready <= 1'b0;
              end else begin
                r_state <= ST_ACCUM;
              end
            end
          end
        end
        ST_OUT, ST_ERROR: begin
          if (NUM_READY) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_num_out   <= '0;
            r_num_valid <= 1'b0;
            r_err       <= 1'b0;
            r_seg_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_seg_ready <= 1'b1;
        end
      endcase
    end
  end

  assign SEG_READY = r_seg_ready;
  assign NUM_OUT   = r_num_out;
  assign NUM_VALID = r_num_valid;
  assign ERR       = r_err;

endmodule

// File: tb/tb_klingon_decoder.sv
// Directed self-checking bench for klingon_decoder (MAX_DIGITS = 3).
module tb_klingon_decoder;

  logic       CLK;
  logic       RST;
  logic [6:0] SEG_IN;
  logic       SEG_VALID;
  logic       LAST;
  logic       SEG_READY;
  logic [9:0] NUM_OUT;
  logic       NUM_VALID;
  logic       NUM_READY;
  logic       ERR;

  int unsigned n_checks;
  int unsigned n_fail;

  klingon_decoder #(.MAX_DIGITS(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SEG_IN    (SEG_IN),
    .SEG_VALID (SEG_VALID),
    .LAST      (LAST),
    .SEG_READY (SEG_READY),
    .NUM_OUT   (NUM_OUT),
    .NUM_VALID (NUM_VALID),
    .NUM_READY (NUM_READY),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one digit at the falling edge, hold until accepted, then sample at +1
  task automatic send(input logic [6:0] seg, input logic last);
    int unsigned n;
    @(negedge CLK);
    SEG_IN    = seg;
    LAST      = last;
    SEG_VALID = 1'b1;
    n = 0;
    while (!SEG_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("seg_ready_wait", {31'b0, (n < 50)}, 32'd1);
    @(posedge CLK);
    #1;
    SEG_VALID = 1'b0;
    LAST      = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    RST       = 1'b1;
    SEG_IN    = '0;
    SEG_VALID = 1'b0;
    LAST      = 1'b0;
    NUM_READY = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_num_valid", NUM_VALID, 0);
    chk("rst_num_out", NUM_OUT, 0);
    chk("rst_err", ERR, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("rst_seg_ready", SEG_READY, 1);

    // 4, 2 -> 42
    NUM_READY = 1'b1;
    send(7'b0100011, 1'b0);
    chk("d42_mid_valid", NUM_VALID, 0);
    send(7'b1000001, 1'b1);
    chk("d42_valid", NUM_VALID, 1);
    chk("d42_out", NUM_OUT, 42);
    chk("d42_err", ERR, 0);
    chk("d42_seg_ready", SEG_READY, 0);
    @(posedge CLK);
    #1;
    chk("d42_consumed", NUM_VALID, 0);
    chk("d42_ready_back", SEG_READY, 1);

    // 9, 9, 9 with LAST=0 -> forced termination at 999
    NUM_READY = 1'b0;
    send(7'b0110111, 1'b0);
    send(7'b0110111, 1'b0);
    chk("d999_two_valid", NUM_VALID, 0);
    chk("d999_two_ready", SEG_READY, 1);
    send(7'b0110111, 1'b0);
    chk("d999_valid", NUM_VALID, 1);
    chk("d999_out", NUM_OUT, 999);
    chk("d999_err", ERR, 0);
    @(posedge CLK);
    #1;
    chk("d999_hold", NUM_OUT, 999);
    NUM_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk("d999_consumed", NUM_VALID, 0);

    // 1 then illegal 1111111 -> error, then 5
    NUM_READY = 1'b0;
    send(7'b1000000, 1'b0);
    send(7'b1111111, 1'b0);
    chk("bad_valid", NUM_VALID, 1);
    chk("bad_err", ERR, 1);
    chk("bad_out", NUM_OUT, 0);
    chk("bad_seg_ready", SEG_READY, 0);
    NUM_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk("bad_consumed", NUM_VALID, 0);
    chk("bad_err_clear", ERR, 0);
    send(7'b0011101, 1'b1);
    chk("after_bad_out", NUM_OUT, 5);
    chk("after_bad_err", ERR, 0);
    chk("after_bad_valid", NUM_VALID, 1);
    @(posedge CLK);
    #1;

    // 7 held under backpressure for 10 cycles with a digit pending
    NUM_READY = 1'b0;
    send(7'b0010011, 1'b1);
    chk("stall_out0", NUM_OUT, 7);
    SEG_IN    = 7'b1000000;
    LAST      = 1'b1;
    SEG_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      chk("stall_out", NUM_OUT, 7);
      chk("stall_valid", NUM_VALID, 1);
      chk("stall_seg_ready", SEG_READY, 0);
    end
    @(negedge CLK);
    SEG_VALID = 1'b0;
    LAST      = 1'b0;
    NUM_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk("stall_consumed", NUM_VALID, 0);
    @(posedge CLK);
    #1;
    chk("stall_once", NUM_VALID, 0);
    chk("stall_seg_ready_back", SEG_READY, 1);

    // Asynchronous reset while a result is pending
    NUM_READY = 1'b0;
    send(7'b0110110, 1'b1);
    chk("pend8_out", NUM_OUT, 8);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("async_valid", NUM_VALID, 0);
    chk("async_out", NUM_OUT, 0);
    chk("async_seg_ready", SEG_READY, 1);
    @(negedge CLK);
    RST = 1'b0;

    // Reset between digits: 8, RST, 3 -> 3
    send(7'b0110110, 1'b0);
    chk("mid_valid", NUM_VALID, 0);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_valid", NUM_VALID, 0);
    chk("mid_rst_err", ERR, 0);
    @(negedge CLK);
    RST = 1'b0;
    NUM_READY = 1'b1;
    send(7'b1001001, 1'b1);
    chk("mid_out", NUM_OUT, 3);
    chk("mid_out_valid", NUM_VALID, 1);
    @(posedge CLK);
    #1;

    // Inputs ignored while SEG_VALID is low
    @(negedge CLK);
    SEG_IN = 7'b1111111;
    LAST   = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("idle_ignore_valid", NUM_VALID, 0);
    chk("idle_ignore_err", ERR, 0);
    LAST = 1'b0;

    // Blank symbol
`ifdef KLINGON_BLANK_EN
    send(7'b0000000, 1'b0);
    chk("blank_first_valid", NUM_VALID, 0);
    send(7'b0100101, 1'b0);
    send(7'b0000000, 1'b1);
    chk("blank_out", NUM_OUT, 6);
    chk("blank_err", ERR, 0);
    chk("blank_valid", NUM_VALID, 1);
`else
    send(7'b0000000, 1'b0);
    chk("blank_valid", NUM_VALID, 1);
    chk("blank_err", ERR, 1);
    chk("blank_out", NUM_OUT, 0);
`endif
    @(posedge CLK);
    #1;
    chk("final_consumed", NUM_VALID, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
